// File: rtl/des_key_schedule_if.sv
// Handshake bundle for des_key_schedule.
//   Key side    : key_valid/key_ready carry a 64-bit key and a decrypt flag; abort flushes.
//   Subkey side : subkey_valid/subkey_ready carry a 48-bit subkey, its issue position
//                 (round_idx) and a last flag; busy mirrors the RUN state.
// The slave modport belongs to the key-schedule block. The master modport is for the
// producer/consumer driving it.
interface des_key_schedule_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        abort;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        last;
  logic        busy;

  modport master (
    output key_valid, key, decrypt, abort, subkey_ready,
    input  key_ready, subkey_valid, subkey, round_idx, last, busy
  );

  modport slave (
    input  key_valid, key, decrypt, abort, subkey_ready,
    output key_ready, subkey_valid, subkey, round_idx, last, busy
  );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule. One 64-bit key is accepted in IDLE. In RUN the block
// then issues the sixteen 48-bit round subkeys, one per handshake: K1..K16 for
// encrypt and K16..K1 for decrypt.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ks_io : key/subkey handshake bundle (slave side)
// C/D hold the rotated PC-1 halves. The subkey is PC-2 of the C/D registers only.
module des_key_schedule (
  input  logic                 clk,
  input  logic                 rst_n,
  des_key_schedule_if.slave    ks_io
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // DES bit numbers: 1 is the MSB of the key and of the concatenated C/D.
  localparam int unsigned Pc1Tbl [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tbl [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  idx_q, idx_d;
  logic        mode_q, mode_d;

  logic [55:0] pc1_out;
  logic [55:0] cd;
  logic [47:0] pc2_out;
  logic        rot_one;

  // PC-1: pure wiring from the key port.
  always_comb begin
    pc1_out = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_out[6'(55 - i)] = ks_io.key[6'(64 - Pc1Tbl[i])];
    end
  end

  // PC-2: pure wiring from the C/D registers.
  assign cd = {c_q, d_q};
  always_comb begin
    pc2_out = '0;
    for (int i = 0; i < 48; i++) begin
      pc2_out[6'(47 - i)] = cd[6'(56 - Pc2Tbl[i])];
    end
  end

  // Single-step positions are the same in both modes. For encrypt the next shift is
  // S[idx+1] and for decrypt it is S[15-idx]. Both are 1 exactly when idx is 0, 7 or 14.
  assign rot_one = (idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    if (ks_io.abort) begin
      state_d = StIdle;
      idx_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ks_io.key_valid) begin
            // Encrypt preloads the first left shift so that K1 appears immediately.
            // Decrypt starts unrotated because a total shift of 28 gives K16.
            if (ks_io.decrypt) begin
              c_d = pc1_out[55:28];
              d_d = pc1_out[27:0];
            end else begin
              c_d = {pc1_out[54:28], pc1_out[55]};
              d_d = {pc1_out[26:0], pc1_out[27]};
            end
            mode_d  = ks_io.decrypt;
            idx_d   = 4'd0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (ks_io.subkey_ready) begin
            if (idx_q == 4'd15) begin
              state_d = StIdle;
              idx_d   = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
              if (mode_q) begin
                c_d = rot_one ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
                d_d = rot_one ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
              end else begin
                c_d = rot_one ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
                d_d = rot_one ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  assign ks_io.key_ready    = (state_q == StIdle);
  assign ks_io.subkey_valid = (state_q == StRun);
  assign ks_io.busy         = (state_q == StRun);
  assign ks_io.subkey       = pc2_out;
  assign ks_io.round_idx    = idx_q;
  assign ks_io.last         = (state_q == StRun) && (idx_q == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule. Expected subkeys are built from the DES definition:
// PC-1 halves, a cumulative left shift, then PC-2.
module tb_des_key_schedule;

  localparam int Pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int Pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [47:0] got [16];
  logic [47:0] enc_got [16];

  des_key_schedule_if ks_if ();

  des_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks_io (ks_if.slave)
  );

  always #5 clk = ~clk;

  // Reference: DES round r (1..16) subkey of key k.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int r);
    logic cdb [1:56];
    logic [47:0] res;
    int t;
    t = 0;
    for (int i = 0; i < r; i++) t += Shifts[i];
    for (int j = 1; j <= 28; j++) begin
      cdb[j]      = k[64 - Pc1[(j - 1 + t) % 28]];
      cdb[j + 28] = k[64 - Pc1[28 + ((j - 1 + t) % 28)]];
    end
    res = '0;
    for (int m = 1; m <= 48; m++) res[48 - m] = cdb[Pc2[m - 1]];
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] k, input logic dec);
    check("accept_key_ready", 64'(ks_if.key_ready), 64'd1);
    ks_if.key_valid    = 1'b1;
    ks_if.key          = k;
    ks_if.decrypt      = dec;
    ks_if.subkey_ready = 1'b0;
    step();
    ks_if.key_valid = 1'b0;
    // Later key/decrypt changes must not disturb the running schedule.
    ks_if.key       = {$urandom, $urandom};
    ks_if.decrypt   = ~dec;
  endtask

  task automatic stream(input logic [63:0] k, input logic dec, input bit rnd_bp, input bit noise);
    int n;
    int cyc;
    logic rdy;
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 400) begin
      rdy = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ks_if.subkey_ready = rdy;
      if (noise) ks_if.key_valid = 1'($urandom_range(0, 1));
      check("subkey_valid", 64'(ks_if.subkey_valid), 64'd1);
      check("key_ready_run", 64'(ks_if.key_ready), 64'd0);
      check("busy_run", 64'(ks_if.busy), 64'd1);
      check("round_idx", 64'(ks_if.round_idx), 64'(n));
      check("subkey", 64'(ks_if.subkey), 64'(ref_subkey(k, dec ? 16 - n : n + 1)));
      check("last", 64'(ks_if.last), 64'(n == 15));
      got[n] = ks_if.subkey;
      step();
      if (rdy) n++;
      cyc++;
    end
    if (n < 16) check("stream_timeout", 64'(n), 64'd16);
    ks_if.key_valid    = 1'b0;
    ks_if.subkey_ready = 1'b0;
    if (!rnd_bp) check("stream_cycles", 64'(cyc), 64'd16);
    check("key_ready_after", 64'(ks_if.key_ready), 64'd1);
    check("valid_after", 64'(ks_if.subkey_valid), 64'd0);
    check("last_after", 64'(ks_if.last), 64'd0);
  endtask

  task automatic run_stream(input logic [63:0] k, input logic dec, input bit rnd_bp,
                            input bit noise);
    accept(k, dec);
    stream(k, dec, rnd_bp, noise);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_key_ready"}, 64'(ks_if.key_ready), 64'd1);
    check({tag, "_valid"}, 64'(ks_if.subkey_valid), 64'd0);
    check({tag, "_idx"}, 64'(ks_if.round_idx), 64'd0);
    check({tag, "_busy"}, 64'(ks_if.busy), 64'd0);
    check({tag, "_last"}, 64'(ks_if.last), 64'd0);
  endtask

  initial begin
    logic [63:0] k0;
    logic [63:0] kr;
    ks_if.key_valid    = 1'b0;
    ks_if.key          = '0;
    ks_if.decrypt      = 1'b0;
    ks_if.abort        = 1'b0;
    ks_if.subkey_ready = 1'b0;
    k0 = 64'h133457799BBCDFF1;

    // Reset values.
    #12;
    check_idle("reset");
    check("reset_subkey", 64'(ks_if.subkey), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Encrypt vector, streaming.
    run_stream(k0, 1'b0, 1'b0, 1'b0);
    check("enc_k1", 64'(got[0]), 64'h1B02EFFC7072);
    check("enc_k2", 64'(got[1]), 64'h79AED9DBC9E5);
    check("enc_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) enc_got[i] = got[i];

    // Decrypt vector: exact reverse of encrypt.
    run_stream(k0, 1'b1, 1'b0, 1'b0);
    check("dec_first", 64'(got[0]), 64'hCB3D8B0E17F5);
    check("dec_last", 64'(got[15]), 64'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) check("dec_reverse", 64'(got[i]), 64'(enc_got[15 - i]));

    // Parity bits ignored.
    run_stream(k0 ^ 64'h0101010101010101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check("parity", 64'(got[i]), 64'(enc_got[i]));

    // Backpressure and ignored key_valid pulses, random keys and modes.
    for (int r = 0; r < 6; r++) begin
      kr = {$urandom, $urandom};
      run_stream(kr, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end

    // Abort after round_idx 5.
    accept(k0, 1'b0);
    ks_if.subkey_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("abort_pre_idx", 64'(ks_if.round_idx), 64'd6);
    check("abort_pre_sk", 64'(ks_if.subkey), 64'(ref_subkey(k0, 7)));
    ks_if.abort        = 1'b1;
    ks_if.subkey_ready = 1'b0;
    step();
    ks_if.abort = 1'b0;
    check_idle("abort");
    // A key offered together with abort is refused.
    ks_if.abort     = 1'b1;
    ks_if.key_valid = 1'b1;
    step();
    ks_if.abort     = 1'b0;
    ks_if.key_valid = 1'b0;
    check_idle("abort_key");
    kr = {$urandom, $urandom};
    run_stream(kr, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges in RUN.
    accept(kr, 1'b1);
    ks_if.subkey_ready = 1'b1;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_subkey", 64'(ks_if.subkey), 64'd0);
    ks_if.subkey_ready = 1'b0;
    step();
    check("rst_held_valid", 64'(ks_if.subkey_valid), 64'd0);
    rst_n = 1'b1;
    run_stream(k0, 1'b0, 1'b0, 1'b0);
    check("post_rst_k1", 64'(got[0]), 64'(enc_got[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
